// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the pipelined ALU control decoder.
// Holds the ALUOp classes, ALU control codes, R-type funct values and
// the per-stage payload struct carried down the pipeline.
package alu_ctrl_pkg;

  // ALUOp classes produced by the main control unit
  typedef enum logic [2:0] {
    OpAdd   = 3'b000,
    OpSub   = 3'b001,
    OpRtype = 3'b010,
    OpAnd   = 3'b011,
    OpOr    = 3'b100,
    OpXor   = 3'b101,
    OpSlt   = 3'b110,
    OpSltu  = 3'b111
  } alu_op_e;

  // ALU operation codes (low 4 bits of alu_ctrl)
  typedef enum logic [3:0] {
    CtrlAnd  = 4'b0000,
    CtrlOr   = 4'b0001,
    CtrlAdd  = 4'b0010,
    CtrlSll  = 4'b0011,
    CtrlSrl  = 4'b0100,
    CtrlSra  = 4'b0101,
    CtrlSub  = 4'b0110,
    CtrlSlt  = 4'b0111,
    CtrlXor  = 4'b1000,
    CtrlSltu = 4'b1001,
    CtrlNor  = 4'b1100
  } alu_ctrl_e;

  // R-type funct field values
  localparam logic [5:0] FnSll  = 6'b000000;
  localparam logic [5:0] FnSrl  = 6'b000010;
  localparam logic [5:0] FnSra  = 6'b000011;
  localparam logic [5:0] FnJr   = 6'b001000;
  localparam logic [5:0] FnAdd  = 6'b100000;
  localparam logic [5:0] FnAddu = 6'b100001;
  localparam logic [5:0] FnSub  = 6'b100010;
  localparam logic [5:0] FnSubu = 6'b100011;
  localparam logic [5:0] FnAnd  = 6'b100100;
  localparam logic [5:0] FnOr   = 6'b100101;
  localparam logic [5:0] FnXor  = 6'b100110;
  localparam logic [5:0] FnNor  = 6'b100111;
  localparam logic [5:0] FnSlt  = 6'b101010;
  localparam logic [5:0] FnSltu = 6'b101011;

  // Decoded payload held in each pipeline stage
  typedef struct packed {
    alu_ctrl_e ctrl;
    logic      shamt_sel;
    logic      illegal;
  } payload_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Pure combinational ALU control decode.
//   alu_op_i  : ALUOp class from main control
//   funct_i   : instruction[5:0], only looked at for R-type
//   payload_o : {ALU control code, shamt select, illegal-funct flag}
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
(
  input  logic [2:0] alu_op_i,
  input  logic [5:0] funct_i,
  output payload_t   payload_o
);

  always_comb begin
    payload_o.ctrl      = CtrlAdd;
    payload_o.shamt_sel = 1'b0;
    payload_o.illegal   = 1'b0;
    case (alu_op_e'(alu_op_i))
      OpAdd:  payload_o.ctrl = CtrlAdd;
      OpSub:  payload_o.ctrl = CtrlSub;
      OpAnd:  payload_o.ctrl = CtrlAnd;
      OpOr:   payload_o.ctrl = CtrlOr;
      OpXor:  payload_o.ctrl = CtrlXor;
      OpSlt:  payload_o.ctrl = CtrlSlt;
      OpSltu: payload_o.ctrl = CtrlSltu;
      OpRtype: begin
        case (funct_i)
          FnAdd, FnAddu, FnJr: payload_o.ctrl = CtrlAdd;
          FnSub, FnSubu:       payload_o.ctrl = CtrlSub;
          FnAnd:               payload_o.ctrl = CtrlAnd;
          FnOr:                payload_o.ctrl = CtrlOr;
          FnXor:               payload_o.ctrl = CtrlXor;
          FnNor:               payload_o.ctrl = CtrlNor;
          FnSlt:               payload_o.ctrl = CtrlSlt;
          FnSltu:              payload_o.ctrl = CtrlSltu;
          FnSll: begin
            payload_o.ctrl      = CtrlSll;
            payload_o.shamt_sel = 1'b1;
          end
          FnSrl: begin
            payload_o.ctrl      = CtrlSrl;
            payload_o.shamt_sel = 1'b1;
          end
          FnSra: begin
            payload_o.ctrl      = CtrlSra;
            payload_o.shamt_sel = 1'b1;
          end
          // Unsupported funct still drives ADD so EX does something harmless
          default: payload_o.illegal = 1'b1;
        endcase
      end
      default: payload_o.ctrl = CtrlAdd;
    endcase
  end

endmodule

// File: rtl/alu_control_pipe.sv
// Pipelined ALU control decoder between ID and EX.
//   clk, rst_n         : clock, synchronous active-low reset
//   in_valid           : alu_op/funct valid this cycle
//   stall / flush      : hold all stages / invalidate all stages (flush wins)
//   alu_op, funct      : ALUOp class and instruction[5:0]
//   out_valid          : outputs below are valid
//   alu_ctrl           : ALU operation code (upper bits zero when CTRL_W > 4)
//   shamt_sel          : ALU B operand takes shamt
//   illegal            : R-type with unsupported funct
//   ill_count          : saturating count of accepted illegal functs
// CTRL_W must be at least 4; STAGES must be 1 or 2.
module alu_control_pipe
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned CTRL_W    = 4,
  parameter int unsigned STAGES    = 1,
  parameter int unsigned ILL_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic                 stall,
  input  logic                 flush,
  input  logic [2:0]           alu_op,
  input  logic [5:0]           funct,
  output logic                 out_valid,
  output logic [CTRL_W-1:0]    alu_ctrl,
  output logic                 shamt_sel,
  output logic                 illegal,
  output logic [ILL_CNT_W-1:0] ill_count
);

  payload_t dec;

  alu_ctrl_decode u_decode (
    .alu_op_i  (alu_op),
    .funct_i   (funct),
    .payload_o (dec)
  );

  logic [STAGES-1:0]    vld_q, vld_d;
  payload_t             pld_q [STAGES];
  payload_t             pld_d [STAGES];
  logic [ILL_CNT_W-1:0] ill_cnt_q, ill_cnt_d;
  logic                 accept;

  assign accept = in_valid & ~stall & ~flush;

  always_comb begin
    vld_d = vld_q;
    for (int i = 0; i < STAGES; i++) pld_d[i] = pld_q[i];
    if (flush) begin
      // Only valid bits drop; payload holds
      vld_d = '0;
    end else if (!stall) begin
      vld_d[0] = in_valid;
      pld_d[0] = dec;
      for (int i = 1; i < STAGES; i++) begin
        vld_d[i] = vld_q[i-1];
        pld_d[i] = pld_q[i-1];
      end
    end
  end

  always_comb begin
    ill_cnt_d = ill_cnt_q;
    if (accept && dec.illegal && (ill_cnt_q != '1)) begin
      ill_cnt_d = ill_cnt_q + ILL_CNT_W'(1'b1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q     <= '0;
      ill_cnt_q <= '0;
      for (int i = 0; i < STAGES; i++) pld_q[i] <= '0;
    end else begin
      vld_q     <= vld_d;
      ill_cnt_q <= ill_cnt_d;
      for (int i = 0; i < STAGES; i++) pld_q[i] <= pld_d[i];
    end
  end

  always_comb begin
    alu_ctrl      = '0;
    alu_ctrl[3:0] = pld_q[STAGES-1].ctrl;
  end

  assign out_valid = vld_q[STAGES-1];
  assign shamt_sel = pld_q[STAGES-1].shamt_sel;
  assign illegal   = pld_q[STAGES-1].illegal;
  assign ill_count = ill_cnt_q;

endmodule

// File: tb/tb_alu_control_pipe.sv
// Bench for alu_control_pipe: two instances (1 stage / 8-bit counter / 4-bit code and
// 2 stages / 2-bit counter / 6-bit code) share one stimulus stream; a queue model
// tracks in-flight ops by age and a negedge process compares every cycle.
module tb_alu_control_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0, in_valid = 1'b0, stall = 1'b0, flush = 1'b0;
  logic [2:0] alu_op = '0;
  logic [5:0] funct = '0;

  logic       ov0, sh0, il0, ov1, sh1, il1;
  logic [3:0] ctrl0;
  logic [5:0] ctrl1;
  logic [7:0] cnt0;
  logic [1:0] cnt1;

  alu_control_pipe #(.CTRL_W(4), .STAGES(1), .ILL_CNT_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall), .flush(flush),
    .alu_op(alu_op), .funct(funct), .out_valid(ov0), .alu_ctrl(ctrl0),
    .shamt_sel(sh0), .illegal(il0), .ill_count(cnt0)
  );

  alu_control_pipe #(.CTRL_W(6), .STAGES(2), .ILL_CNT_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall), .flush(flush),
    .alu_op(alu_op), .funct(funct), .out_valid(ov1), .alu_ctrl(ctrl1),
    .shamt_sel(sh1), .illegal(il1), .ill_count(cnt1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Returns {illegal, shamt_sel, ctrl[3:0]} straight from the decode tables
  function automatic logic [5:0] ref_dec(input logic [2:0] op, input logic [5:0] f);
    case (op)
      3'd0: return 6'd2;
      3'd1: return 6'd6;
      3'd3: return 6'd0;
      3'd4: return 6'd1;
      3'd5: return 6'd8;
      3'd6: return 6'd7;
      3'd7: return 6'd9;
      default: begin
        case (f)
          6'b100000, 6'b100001, 6'b001000: return 6'd2;
          6'b100010, 6'b100011: return 6'd6;
          6'b100100: return 6'd0;
          6'b100101: return 6'd1;
          6'b100110: return 6'd8;
          6'b100111: return 6'd12;
          6'b101010: return 6'd7;
          6'b101011: return 6'd9;
          6'b000000: return 6'b01_0011;
          6'b000010: return 6'b01_0100;
          6'b000011: return 6'b01_0101;
          default:   return 6'b10_0010;
        endcase
      end
    endcase
  endfunction

  // Model: each accepted op ages by one per non-stalled edge and is visible at age == STAGES
  typedef struct {
    logic [5:0] p;
    int         age;
  } ent_t;

  ent_t mq [2][$];
  int   mcnt [2] = '{0, 0};
  int   stg  [2] = '{1, 2};
  int   cmax [2] = '{255, 3};
  bit   armed = 1'b0;

  always @(posedge clk) begin
    ent_t       nq[$];
    ent_t       e;
    logic [5:0] pp;
    pp = ref_dec(alu_op, funct);
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        mq[d].delete();
        mcnt[d] = 0;
      end else if (flush) begin
        mq[d].delete();
      end else if (!stall) begin
        nq.delete();
        for (int i = 0; i < mq[d].size(); i++) begin
          if (mq[d][i].age < stg[d]) begin
            e.p   = mq[d][i].p;
            e.age = mq[d][i].age + 1;
            nq.push_back(e);
          end
        end
        if (in_valid) begin
          e.p   = pp;
          e.age = 1;
          nq.push_back(e);
          if (pp[5] && mcnt[d] < cmax[d]) mcnt[d]++;
        end
        mq[d] = nq;
      end
    end
    if (!rst_n) armed = 1'b1;
  end

  always @(negedge clk) begin
    int         a_v [2], a_c [2], a_s [2], a_i [2], a_n [2];
    bit         ev;
    logic [5:0] ep;
    if (armed) begin
      a_v[0] = int'(ov0); a_c[0] = int'(ctrl0); a_s[0] = int'(sh0);
      a_i[0] = int'(il0); a_n[0] = int'(cnt0);
      a_v[1] = int'(ov1); a_c[1] = int'(ctrl1); a_s[1] = int'(sh1);
      a_i[1] = int'(il1); a_n[1] = int'(cnt1);
      for (int d = 0; d < 2; d++) begin
        ev = 1'b0;
        ep = '0;
        for (int i = 0; i < mq[d].size(); i++) begin
          if (mq[d][i].age == stg[d]) begin
            ev = 1'b1;
            ep = mq[d][i].p;
          end
        end
        chk($sformatf("d%0d.out_valid", d), a_v[d], int'(ev));
        if (ev) begin
          chk($sformatf("d%0d.alu_ctrl", d), a_c[d], int'(ep[3:0]));
          chk($sformatf("d%0d.shamt_sel", d), a_s[d], int'(ep[4]));
          chk($sformatf("d%0d.illegal", d), a_i[d], int'(ep[5]));
        end
        chk($sformatf("d%0d.ill_count", d), a_n[d], mcnt[d]);
      end
    end
  end

  // One clock edge with the given inputs; returns 1 time unit after the edge
  task automatic drive(input logic r, input logic iv, input logic st, input logic fl,
                       input logic [2:0] op, input logic [5:0] fn);
    rst_n    = r;
    in_valid = iv;
    stall    = st;
    flush    = fl;
    alu_op   = op;
    funct    = fn;
    @(posedge clk);
    #1;
  endtask

  logic [3:0] sweep_tab [8] = '{4'd2, 4'd6, 4'd5, 4'd0, 4'd1, 4'd8, 4'd7, 4'd9};
  int         ill_seq   [5] = '{1, 2, 3, 3, 3};
  logic [5:0] legal_fn  [14] = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100,
                                 6'b100101, 6'b100110, 6'b100111, 6'b101010, 6'b101011,
                                 6'b000000, 6'b000010, 6'b000011, 6'b001000};

  initial begin
    logic [5:0] fn;
    drive(0, 0, 0, 0, 3'd0, 6'd0);
    drive(0, 0, 0, 0, 3'd0, 6'd0);
    chk("rst.d0.out_valid", int'(ov0), 0);
    chk("rst.d0.alu_ctrl", int'(ctrl0), 0);
    chk("rst.d0.shamt_sel", int'(sh0), 0);
    chk("rst.d0.illegal", int'(il0), 0);
    chk("rst.d0.ill_count", int'(cnt0), 0);
    chk("rst.d1.out_valid", int'(ov1), 0);
    chk("rst.d1.alu_ctrl", int'(ctrl1), 0);
    chk("rst.d1.ill_count", int'(cnt1), 0);

    // R-type sub on the single-stage instance
    drive(1, 1, 0, 0, 3'b010, 6'b100010);
    chk("sub.d0.out_valid", int'(ov0), 1);
    chk("sub.d0.alu_ctrl", int'(ctrl0), 6);
    chk("sub.d0.shamt_sel", int'(sh0), 0);
    chk("sub.d0.illegal", int'(il0), 0);

    // funct = sra under every class: only R-type honours it
    for (int op = 0; op < 8; op++) begin
      drive(1, 1, 0, 0, 3'(op), 6'b000011);
      chk($sformatf("sweep%0d.alu_ctrl", op), int'(ctrl0), int'(sweep_tab[op]));
      chk($sformatf("sweep%0d.shamt_sel", op), int'(sh0), (op == 2) ? 1 : 0);
    end

    // Two-stage: A (add) then B (nor) held off by a 2-cycle stall
    drive(0, 0, 0, 0, 3'd0, 6'd0);
    drive(1, 1, 0, 0, 3'b010, 6'b100000);
    chk("stl.e1.out_valid", int'(ov1), 0);
    drive(1, 1, 1, 0, 3'b010, 6'b100111);
    chk("stl.e2.out_valid", int'(ov1), 0);
    drive(1, 1, 1, 0, 3'b010, 6'b100111);
    chk("stl.e3.out_valid", int'(ov1), 0);
    drive(1, 1, 0, 0, 3'b010, 6'b100111);
    chk("stl.e4.out_valid", int'(ov1), 1);
    chk("stl.e4.alu_ctrl", int'(ctrl1), 2);
    drive(1, 0, 0, 0, 3'd0, 6'd0);
    chk("stl.e5.out_valid", int'(ov1), 1);
    chk("stl.e5.alu_ctrl", int'(ctrl1), 12);
    drive(1, 0, 0, 0, 3'd0, 6'd0);
    chk("stl.e6.out_valid", int'(ov1), 0);

    // Flush together with stall and an incoming illegal op
    drive(0, 0, 0, 0, 3'd0, 6'd0);
    drive(1, 1, 0, 0, 3'b010, 6'b100000);
    chk("fl.pre.d0.out_valid", int'(ov0), 1);
    drive(1, 1, 1, 1, 3'b010, 6'b111111);
    chk("fl.d0.out_valid", int'(ov0), 0);
    chk("fl.d1.out_valid", int'(ov1), 0);
    chk("fl.d0.ill_count", int'(cnt0), 0);
    drive(1, 0, 0, 0, 3'd0, 6'd0);
    chk("fl.post.d1.out_valid", int'(ov1), 0);

    // Illegal functs: 2-bit counter saturates at 3
    drive(0, 0, 0, 0, 3'd0, 6'd0);
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 0, 0, 3'b010, 6'b111111);
      chk($sformatf("ill%0d.d1.ill_count", i), int'(cnt1), ill_seq[i]);
      chk($sformatf("ill%0d.d0.ill_count", i), int'(cnt0), i + 1);
      chk($sformatf("ill%0d.d0.illegal", i), int'(il0), 1);
      chk($sformatf("ill%0d.d0.alu_ctrl", i), int'(ctrl0), 2);
    end

    // Reset with two ops in flight in the two-stage instance
    drive(1, 1, 0, 0, 3'b010, 6'b100100);
    drive(1, 1, 0, 0, 3'b100, 6'd0);
    drive(0, 1, 0, 0, 3'b010, 6'b000000);
    chk("rif.d1.out_valid", int'(ov1), 0);
    chk("rif.d1.alu_ctrl", int'(ctrl1), 0);
    chk("rif.d1.shamt_sel", int'(sh1), 0);
    chk("rif.d1.illegal", int'(il1), 0);
    chk("rif.d1.ill_count", int'(cnt1), 0);
    chk("rif.d0.out_valid", int'(ov0), 0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 3'd0, 6'd0);
      chk($sformatf("rif.post%0d.d1.out_valid", i), int'(ov1), 0);
    end

    // Random traffic, checked every cycle by the compare process
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 1) == 0) fn = legal_fn[$urandom_range(0, 13)];
      else fn = 6'($urandom);
      drive(($urandom_range(0, 99) != 0), ($urandom_range(0, 9) < 7),
            ($urandom_range(0, 9) < 2), ($urandom_range(0, 19) == 0),
            3'($urandom), fn);
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
